inst_fetch_resp: RTL
====================

Name: inst_fetch_resp

Overview:
Instruction-fetch responder on the far side of the PC/fetch interface. It samples the fetch address `pc` and chip-enable `ce` from the PC stage and reads a word-addressed on-chip instruction memory with a fixed multi-cycle latency. While a fetch is outstanding it raises a stall request back to the pipeline controller. It supports pipeline flush and has a side port for loading the memory.

Parameters:
- ADDR_W, 10, word-address bits; memory depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, memory access cycles per fetch; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ce  in  1  fetch enable from PC stage; 0 means no fetch.
- pc  in  32  byte address of the requested instruction.
- flush  in  1  pipeline flush; abort any outstanding fetch.
- ld_we  in  1  load-port write enable.
- ld_addr  in  ADDR_W  load-port word address.
- ld_data  in  32  load-port write data.
- inst_o  out  32  fetched instruction.
- inst_valid_o  out  1  one-cycle pulse: inst_o holds a new instruction.
- addr_err_o  out  1  accompanies inst_valid_o; the fetch was misaligned or out of range.
- stallreq_o  out  1  stall request to the controller (drives stall[0] upstream).

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0.
  - inst_o=0, inst_valid_o=0, addr_err_o=0, captured address=0.
  - Memory contents are not cleared.
  - Reset dominates flush, ce and ld_we, except that a load-port write in the same cycle still commits.
- States: IDLE, BUSY. Down-counter cnt is 4 bits.
- IDLE, ce=1 and flush=0 at a posedge (accept edge):
  - capture pc;
  - cnt <= LATENCY-1;
  - go to BUSY.
- IDLE otherwise: stay in IDLE.
- BUSY, flush=0:
  - cnt>0: cnt decrements.
  - cnt==0 (complete edge): return to IDLE; register inst_o and addr_err_o; inst_valid_o <= 1 for exactly the following cycle.
- inst_valid_o is 0 in every cycle not directly after a complete edge.
- Data formation at the complete edge:
  - Misaligned fetch: captured pc[1:0] != 0.
  - Out of range: captured pc[31:ADDR_W+2] != 0.
  - If either condition holds: inst_o=0 (NOP), addr_err_o=1.
  - Otherwise: inst_o=mem[pc[ADDR_W+1:2]], addr_err_o=0.
- stallreq_o is combinational and equals ce & ~flush & ~(state==BUSY & cnt==0).
  - It is high from the accept cycle through BUSY with cnt>0.
  - It drops in the completing cycle, so the PC advances on the same edge that inst_o is registered.
- Throughput: LATENCY+1 cycles per fetch. The next fetch is accepted in the IDLE cycle that follows completion.
- Flush (flush=1 at a posedge, any state):
  - state <= IDLE, cnt <= 0;
  - inst_valid_o <= 0, inst_o <= 0, addr_err_o <= 0;
  - the in-flight result is discarded, never delivered;
  - no new request is accepted that edge;
  - stallreq_o=0 during the flush cycle.
- ce=0 while in BUSY: the fetch is abandoned at the next edge, exactly like flush. A PC stage that is disabled makes no further use of the result.
- pc changing while in BUSY: ignored; the captured address is used.
- Load port: mem[ld_addr] <= ld_data at the posedge when ld_we=1, independent of state.
  - If a load-port write hits the address being read on the complete edge, the read returns the pre-write value (read-before-write).
  - The written value is visible to any later complete edge.
- The block has no combinational path from pc to inst_o.

Test Plan:
1. Basic fetch (LATENCY=2):
   - Stimulus: load mem[0]=0x24010005, mem[1]=0x24020007, then drive rst=1 for 2 cycles, then ce=1, pc=0.
   - Required: stallreq_o=1 for 2 cycles and 0 in the 3rd; inst_valid_o pulses in cycle 4 with inst_o=0x24010005.
   - Then drive pc=4; the next pulse comes 3 cycles later with 0x24020007.
2. Latency sweep:
   - Stimulus: LATENCY=1 and LATENCY=5, streaming pc=0,4,8.
   - Required: valid pulses every 2 and 6 cycles respectively; data in order; addr_err_o=0.
3. Misaligned and out-of-range fetch:
   - Stimulus: pc=0x00000002, then pc=0x00001000 with ADDR_W=10.
   - Required: each delivers inst_o=0 with addr_err_o=1; stallreq_o sequencing is identical to a normal fetch.
4. Flush mid-fetch:
   - Stimulus: accept pc=8, assert flush for 1 cycle while BUSY with cnt>0.
   - Required: no inst_valid_o pulse for pc=8; inst_o=0; stallreq_o=0 in the flush cycle; a new fetch of pc=0x10 is accepted on the next edge and delivers normally.
5. Load-port collision:
   - Stimulus: mem[3]=0xAAAA0000; fetch pc=0xC; write mem[3]=0xBBBB0000 on the complete edge.
   - Required: delivered 0xAAAA0000; a refetch of 0xC delivers 0xBBBB0000.
6. Reset mid-fetch and ce drop:
   - Stimulus: rst=1 while BUSY.
   - Required: next cycle inst_valid_o=0, inst_o=0, stallreq_o follows ce.
   - Stimulus: ce=0 while BUSY.
   - Required: no pulse delivered; stallreq_o=0.

Source files
------------

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: reads a word-addressed on-chip instruction memory
// with a fixed multi-cycle latency, stalls the pipeline while busy, and supports flush.
module inst_fetch_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       pc,
  input  logic              flush,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              addr_err_o,
  output logic              stallreq_o
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] addr_r;
  logic        accept_s, complete_s, clear_s;
  logic [31:0] mem_r [0:DEPTH-1];

  // A fetch is rejected when it is not word aligned or lies beyond the memory.
  function automatic logic fetch_addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
  endfunction

  // Next-state and event decode; ce dropping while busy abandons like a flush.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    complete_s = 1'b0;
    clear_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          clear_s = 1'b1;
          cnt_s   = 4'd0;
        end else if (ce) begin
          accept_s = 1'b1;
          state_s  = BUSY;
          cnt_s    = CNT_START;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (flush || !ce) begin
          clear_s = 1'b1;
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          complete_s = 1'b1;
          state_s    = IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Stall drops in the completing cycle so the PC advances on the delivery edge.
  assign stallreq_o = ce & ~flush & ~((state_r == BUSY) && (cnt_r == 4'd0));

  // Control state, captured address and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      addr_r       <= 32'd0;
      inst_o       <= 32'd0;
      inst_valid_o <= 1'b0;
      addr_err_o   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      inst_valid_o <= complete_s;
      if (accept_s) begin
        addr_r <= pc;
      end
      if (complete_s) begin
        inst_o     <= fetch_addr_bad(addr_r) ? 32'd0 : mem_r[addr_r[ADDR_W+1:2]];
        addr_err_o <= fetch_addr_bad(addr_r);
      end else if (clear_s) begin
        inst_o     <= 32'd0;
        addr_err_o <= 1'b0;
      end
    end
  end

  // Load port writes regardless of reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

endmodule
